// File: rtl/cv32e40s_pkg.sv
// Shared register-file integrity definitions: address type, word layout and
// the ECC encoder used by both the write path and the scrubber.
package cv32e40s_pkg;

  localparam int REGFILE_WORD_WIDTH = 38;
  localparam int RF_ADDR_WIDTH      = 5;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

  // Inverting the stored check bits makes the all-zero word invalid,
  // so a stuck-at-zero register file cannot pass the check.
  localparam logic [5:0] RF_ECC_INV = 6'b10_1010;

  localparam logic [5:0][31:0] RF_ECC_MASK = {
    32'hFC00_0000,
    32'h03FF_F800,
    32'h03FC_07F0,
    32'hE3C3_C78E,
    32'h9B33_366D,
    32'h56AA_AD5B
  };

  typedef enum logic [1:0] {
    SCRUB_WAIT,
    SCRUB_REQ,
    SCRUB_CHECK
  } scrub_state_e;

  function automatic logic [5:0] rf_ecc_encode(input logic [31:0] data);
    logic [5:0] ecc;
    ecc = '0;
    for (int k = 0; k < 6; k++) ecc[k] = ^(data & RF_ECC_MASK[k]);
    return ecc;
  endfunction

endpackage

// File: rtl/cv32e40s_rf_scrubber_if.sv
// Spare register-file read port: request/grant with same-cycle read data.
interface cv32e40s_rf_scrubber_if;
  import cv32e40s_pkg::*;

  logic                          rf_req;
  logic                          rf_gnt;
  rf_addr_t                      rf_raddr;
  logic [REGFILE_WORD_WIDTH-1:0] rf_rdata;

  modport master (output rf_req, rf_raddr, input  rf_gnt, rf_rdata);
  modport slave  (input  rf_req, rf_raddr, output rf_gnt, rf_rdata);
endinterface

// File: rtl/cv32e40s_rf_ecc_checker.sv
// Combinational ECC check of one {ecc, data} register-file word.
module cv32e40s_rf_ecc_checker
  import cv32e40s_pkg::*;
(
  input  logic [REGFILE_WORD_WIDTH-1:0] word_i,
  output logic                          err_o
);

  assign err_o = ((rf_ecc_encode(word_i[31:0]) ^ RF_ECC_INV) != word_i[37:32]);

endmodule

// File: rtl/cv32e40s_rf_scrubber.sv
// Background sweep of x1..x31 through a spare read port; flags ECC mismatches
// as a major alert with last failing address and a saturating count.
module cv32e40s_rf_scrubber
  import cv32e40s_pkg::*;
#(
  parameter int unsigned SCRUB_INTERVAL = 16,
  parameter int unsigned ERR_CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scrub_en_i,
  cv32e40s_rf_scrubber_if.master    rf_if,
  output logic                      alert_major_o,
  output rf_addr_t                  err_addr_o,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt_o,
  output logic                      sweep_done_o
);

  localparam int              CNT_W      = (SCRUB_INTERVAL > 0) ? $clog2(SCRUB_INTERVAL + 1) : 1;
  localparam logic [CNT_W-1:0] IVL_RELOAD = CNT_W'(SCRUB_INTERVAL);
  localparam rf_addr_t         ADDR_FIRST = rf_addr_t'(1);
  localparam rf_addr_t         ADDR_LAST  = rf_addr_t'(31);
  localparam logic [REGFILE_WORD_WIDTH-1:0] RST_WORD = {RF_ECC_INV, 32'h0};

  scrub_state_e                  state_q, state_d;
  logic [CNT_W-1:0]              ivl_q, ivl_d;
  rf_addr_t                      addr_q, addr_d;
  logic [REGFILE_WORD_WIDTH-1:0] word_q, word_d;
  logic                          alert_q, alert_d;
  rf_addr_t                      err_addr_q, err_addr_d;
  logic [ERR_CNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;
  logic                          done_q, done_d;
  logic                          req;
  logic                          ecc_err;

  // Checks the captured word, never the live read data, so no output
  // depends combinationally on rf_rdata.
  cv32e40s_rf_ecc_checker u_ecc_chk (
    .word_i (word_q),
    .err_o  (ecc_err)
  );

  always_comb begin
    state_d    = state_q;
    ivl_d      = ivl_q;
    addr_d     = addr_q;
    word_d     = word_q;
    alert_d    = 1'b0;
    done_d     = 1'b0;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    req        = 1'b0;
    case (state_q)
      SCRUB_WAIT: begin
        if (!scrub_en_i) begin
          ivl_d  = IVL_RELOAD;
          addr_d = ADDR_FIRST;
        end else if (ivl_q == '0) begin
          state_d = SCRUB_REQ;
        end else begin
          ivl_d = ivl_q - 1'b1;
        end
      end
      SCRUB_REQ: begin
        if (!scrub_en_i) begin
          state_d = SCRUB_WAIT;
          ivl_d   = IVL_RELOAD;
          addr_d  = ADDR_FIRST;
        end else begin
          req = 1'b1;
          if (rf_if.rf_gnt) begin
            word_d  = rf_if.rf_rdata;
            state_d = SCRUB_CHECK;
          end
        end
      end
      SCRUB_CHECK: begin
        if (ecc_err) begin
          alert_d    = 1'b1;
          err_addr_d = addr_q;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
        done_d  = (addr_q == ADDR_LAST);
        addr_d  = (!scrub_en_i || addr_q == ADDR_LAST) ? ADDR_FIRST : addr_q + 1'b1;
        ivl_d   = IVL_RELOAD;
        state_d = SCRUB_WAIT;
      end
      default: state_d = SCRUB_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCRUB_WAIT;
      ivl_q      <= IVL_RELOAD;
      addr_q     <= ADDR_FIRST;
      word_q     <= RST_WORD;
      alert_q    <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ivl_q      <= ivl_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      alert_q    <= alert_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
      done_q     <= done_d;
    end
  end

  assign rf_if.rf_req   = req;
  assign rf_if.rf_raddr = addr_q;
  assign alert_major_o  = alert_q;
  assign err_addr_o     = err_addr_q;
  assign err_cnt_o      = err_cnt_q;
  assign sweep_done_o   = done_q;

endmodule

// File: tb/tb_cv32e40s_rf_scrubber.sv
// Directed bench: two scrubbers (interval 0 / 2-bit counter, interval 3)
// sharing one modelled register file.
module tb_cv32e40s_rf_scrubber;
  import cv32e40s_pkg::*;

  localparam logic [37:0] RST_WORD  = {6'b10_1010, 32'h0000_0000};
  localparam logic [37:0] BAD_WORD  = {6'b10_1010, 32'h0000_0001};
  localparam logic [37:0] GOOD_WORD = {6'b10_1001, 32'h0000_0001};

  logic clk = 1'b0;
  logic rst_n, en_a, en_b, gnt_a, gnt_b;
  logic alert_a, alert_b, done_a, done_b;
  rf_addr_t err_addr_a, err_addr_b;
  logic [1:0] err_cnt_a;
  logic [7:0] err_cnt_b;
  logic [37:0] rf_mem [32];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cv32e40s_rf_scrubber_if ifa ();
  cv32e40s_rf_scrubber_if ifb ();

  assign ifa.rf_gnt   = gnt_a;
  assign ifa.rf_rdata = rf_mem[ifa.rf_raddr];
  assign ifb.rf_gnt   = gnt_b;
  assign ifb.rf_rdata = rf_mem[ifb.rf_raddr];

  cv32e40s_rf_scrubber #(.SCRUB_INTERVAL(0), .ERR_CNT_WIDTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .scrub_en_i(en_a), .rf_if(ifa),
    .alert_major_o(alert_a), .err_addr_o(err_addr_a), .err_cnt_o(err_cnt_a),
    .sweep_done_o(done_a)
  );

  cv32e40s_rf_scrubber #(.SCRUB_INTERVAL(3), .ERR_CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .scrub_en_i(en_b), .rf_if(ifb),
    .alert_major_o(alert_b), .err_addr_o(err_addr_b), .err_cnt_o(err_cnt_b),
    .sweep_done_o(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Steps until dut_a signals sweep done; reports cycles, alerts, last alert cycle.
  task automatic sweep_a(output int cyc, output int alerts, output int alert_at);
    cyc = 0; alerts = 0; alert_at = -1;
    do begin
      @(negedge clk);
      cyc++;
      if (alert_a) begin alerts++; alert_at = cyc; end
    end while (!done_a && cyc < 400);
    chk("sweep_done_seen", 32'(done_a), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, alerts, at, ok, n;
    logic [1:0] sat_exp [4];
    logic found;
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3};

    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; gnt_a = 1'b1; gnt_b = 1'b1;
    for (int i = 0; i < 32; i++) rf_mem[i] = RST_WORD;
    step(2);
    chk("rst_req",      32'(ifa.rf_req),   0);
    chk("rst_raddr",    32'(ifa.rf_raddr), 1);
    chk("rst_alert",    32'(alert_a),      0);
    chk("rst_err_addr", 32'(err_addr_a),   0);
    chk("rst_err_cnt",  32'(err_cnt_a),    0);
    chk("rst_done",     32'(done_a),       0);
    rst_n = 1'b1; en_a = 1'b1;

    // clean register file: 93-cycle sweeps, no alerts
    sweep_a(cyc, alerts, at);
    chk("t1_sweep1_cycles", 32'(cyc), 93);
    chk("t1_sweep1_alerts", 32'(alerts), 0);
    sweep_a(cyc, alerts, at);
    chk("t1_sweep2_cycles", 32'(cyc), 93);
    chk("t1_sweep2_alerts", 32'(alerts), 0);
    chk("t1_err_cnt", 32'(err_cnt_a), 0);

    // bad x7, valid non-zero x9
    rf_mem[7] = BAD_WORD; rf_mem[9] = GOOD_WORD;
    sweep_a(cyc, alerts, at);
    chk("t2_s1_cycles", 32'(cyc), 93);
    chk("t2_s1_alerts", 32'(alerts), 1);
    chk("t2_s1_alert_at", 32'(at), 21);
    chk("t2_s1_err_addr", 32'(err_addr_a), 7);
    chk("t2_s1_err_cnt", 32'(err_cnt_a), 1);
    sweep_a(cyc, alerts, at);
    chk("t2_s2_alerts", 32'(alerts), 1);
    chk("t2_s2_alert_at", 32'(at), 21);
    chk("t2_s2_err_cnt", 32'(err_cnt_a), 2);
    rf_mem[7] = RST_WORD;

    // grant withheld 50 cycles in REQ at x1
    gnt_a = 1'b0;
    step(1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (ifa.rf_req && ifa.rf_raddr == 5'd1 && !alert_a) ok++;
      step(1);
    end
    chk("t3_stall_cycles", 32'(ok), 50);
    rf_mem[1] = BAD_WORD; gnt_a = 1'b1;
    step(1);
    chk("t3_check_req", 32'(ifa.rf_req), 0);
    step(1);
    chk("t3_alert", 32'(alert_a), 1);
    chk("t3_err_addr", 32'(err_addr_a), 1);
    chk("t3_err_cnt", 32'(err_cnt_a), 3);
    chk("t3_next_addr", 32'(ifa.rf_raddr), 2);
    rf_mem[1] = RST_WORD;

    // reset while checking a bad x5
    rf_mem[5] = BAD_WORD;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1);
      if (ifa.rf_req && ifa.rf_raddr == 5'd5) found = 1'b1;
    end
    chk("t6_reached_x5", 32'(found), 1);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("t6_alert", 32'(alert_a), 0);
    chk("t6_req", 32'(ifa.rf_req), 0);
    chk("t6_raddr", 32'(ifa.rf_raddr), 1);
    chk("t6_err_addr", 32'(err_addr_a), 0);
    chk("t6_err_cnt", 32'(err_cnt_a), 0);
    chk("t6_done", 32'(done_a), 0);
    rf_mem[5] = RST_WORD;
    step(1);
    chk("t6_alert_held", 32'(alert_a), 0);
    rst_n = 1'b1;
    step(1);
    chk("t6_first_req", 32'(ifa.rf_req), 1);
    chk("t6_first_addr", 32'(ifa.rf_raddr), 1);

    // bad x31 with 2-bit counter: saturation, alert coincides with done
    rf_mem[31] = BAD_WORD;
    for (int s = 0; s < 4; s++) begin
      sweep_a(cyc, alerts, at);
      chk("t5_alerts", 32'(alerts), 1);
      chk("t5_alert_with_done", 32'(at), 32'(cyc));
      chk("t5_err_addr", 32'(err_addr_a), 31);
      chk("t5_err_cnt", 32'(err_cnt_a), 32'(sat_exp[s]));
    end
    rf_mem[31] = RST_WORD;

    // interval 3: disable in REQ at x12, restart from x1
    en_b = 1'b1;
    n = 0; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1); n++;
      if (ifb.rf_req && ifb.rf_raddr == 5'd12) found = 1'b1;
    end
    chk("t4_reached_x12", 32'(found), 1);
    chk("t4_cycles_to_x12", 32'(n), 70);
    en_b = 1'b0;
    #1;
    chk("t4_req_drop", 32'(ifb.rf_req), 0);
    step(1);
    chk("t4_raddr_reset", 32'(ifb.rf_raddr), 1);
    chk("t4_req_idle", 32'(ifb.rf_req), 0);
    en_b = 1'b1;
    n = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1); n++;
      if (ifb.rf_req) found = 1'b1;
    end
    chk("t4_restart_delay", 32'(n), 4);
    chk("t4_restart_addr", 32'(ifb.rf_raddr), 1);
    chk("t4_err_cnt", 32'(err_cnt_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
